systolic_data_loader: RTL

//  Stage directly upstream of the systolic array controller. Accepts one framed

---
 rtl/systolic_data_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/systolic_data_loader.sv
// rtl/systolic_data_loader.sv - framed byte stream to four operand RAMs (A0, A1, W0, W1)
//
// Purpose:
//   Accepts one valid/ready framed stream and writes it, in order, into the
//   A0, A1, W0 and W1 operand RAMs, cfg_len_m1+1 words per RAM. Pulses
//   data_load_done once the last W1 write has been issued, which kicks off
//   the systolic array controller downstream.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   load_start          1-cycle frame request (accepted only in IDLE and
//                       only while arr_ctrl_working is low)
//   cfg_len_m1          words per segment minus one, latched on accept
//   arr_ctrl_working    array controller busy, blocks new starts
//   in_data/in_valid/
//   in_last/in_ready    input stream
//   ram_wdata           write data shared by all RAMs
//   ram_*_addr/_wren    per-RAM write address and enable (registered)
//   data_load_done      1-cycle pulse after a correctly framed load
//   loader_busy         high whenever the loader is not IDLE
//   err_framing         sticky in_last mismatch flag, cleared on next start

module systolic_data_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] cfg_len_m1,
    input  logic              arr_ctrl_working,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_a0_addr,
    output logic              ram_a0_wren,
    output logic [ADDR_W-1:0] ram_a1_addr,
    output logic              ram_a1_wren,
    output logic [ADDR_W-1:0] ram_w0_addr,
    output logic              ram_w0_wren,
    output logic [ADDR_W-1:0] ram_w1_addr,
    output logic              ram_w1_wren,
    output logic              data_load_done,
    output logic              loader_busy,
    output logic              err_framing
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_A0 = 3'd1,
        S_LD_A1 = 3'd2,
        S_LD_W0 = 3'd3,
        S_LD_W1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]            len_q, len_d;
    logic                         err_q, err_d;
    logic [3:0]                   wren_q, wren_d;
    // One address register per RAM so each address holds its own last value.
    logic [3:0][ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic                         done_q, done_d;

    logic                         loading;
    logic                         beat;
    logic                         last_word;
    logic                         final_beat;
    logic [1:0]                   seg;
    state_t                       seg_next;

    // Segment index of the RAM being filled and the state that follows it.
    always_comb begin
        seg      = 2'd0;
        seg_next = S_DONE;
        case (state_q)
            S_LD_A0: begin seg = 2'd0; seg_next = S_LD_A1; end
            S_LD_A1: begin seg = 2'd1; seg_next = S_LD_W0; end
            S_LD_W0: begin seg = 2'd2; seg_next = S_LD_W1; end
            S_LD_W1: begin seg = 2'd3; seg_next = S_DONE;  end
            default: begin seg = 2'd0; seg_next = S_DONE;  end
        endcase
    end

    assign loading    = (state_q == S_LD_A0) || (state_q == S_LD_A1) ||
                        (state_q == S_LD_W0) || (state_q == S_LD_W1);
    assign in_ready   = loading;
    assign beat       = in_valid && loading;
    assign last_word  = (cnt_q == len_q);
    assign final_beat = (state_q == S_LD_W1) && last_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        wren_d  = 4'b0000;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // The done pulse trails the DONE state by one cycle.
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (load_start && !arr_ctrl_working) begin
                    state_d = S_LD_A0;
                    cnt_d   = '0;
                    len_d   = cfg_len_m1;
                    err_d   = 1'b0;
                end
            end
            S_LD_A0, S_LD_A1, S_LD_W0, S_LD_W1: begin
                if (beat) begin
                    // The write is issued even when the beat breaks framing.
                    wren_d[seg] = 1'b1;
                    addr_d[seg] = cnt_q;
                    wdata_d     = in_data;
                    if (in_last != final_beat) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else if (last_word) begin
                        cnt_d   = '0;
                        state_d = seg_next;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            wren_q  <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign ram_wdata      = wdata_q;
    assign ram_a0_addr    = addr_q[0];
    assign ram_a1_addr    = addr_q[1];
    assign ram_w0_addr    = addr_q[2];
    assign ram_w1_addr    = addr_q[3];
    assign ram_a0_wren    = wren_q[0];
    assign ram_a1_wren    = wren_q[1];
    assign ram_w0_wren    = wren_q[2];
    assign ram_w1_wren    = wren_q[3];
    assign data_load_done = done_q;
    assign loader_busy    = (state_q != S_IDLE);
    assign err_framing    = err_q;

endmodule
